program_loader: RTL

Boot-time instruction loader that sits directly upstream of the single-cycle CPU's instruction store. It receives a program as a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them sequentially into the instruction memory from address 0. It holds the CPU in reset through its own `cpu_rst` output until a load completes, and it reports a running word checksum.

---
 rtl/program_loader.sv | 96 +++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: assembles big-endian 16-bit words from a byte stream and writes them
// to instruction memory from address 0, holding the CPU in reset until the load completes.
module program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [15:0]           imem_wr_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           checksum
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

    state_t              state_q;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d, len_q;
    logic [15:0]         word_q, csum_q;
    logic                err_q, cpu_rst_q;

    // The counter carries one extra bit so a full-depth load can match len.
    assign cnt_d        = cnt_q + ONE;
    assign byte_ready   = (state_q == HI) || (state_q == LO);
    assign imem_wr_en   = state_q == WRITE;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign imem_addr    = cnt_q[ADDR_WIDTH-1:0];
    assign imem_wr_data = word_q;
    assign err          = err_q;
    assign cpu_rst      = cpu_rst_q;
    assign checksum     = csum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            word_q    <= '0;
            csum_q    <= '0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    if (len > DEPTH) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q  <= 1'b0;
                        csum_q <= '0;
                        if (len == '0) begin
                            cpu_rst_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            cnt_q     <= '0;
                            len_q     <= len;
                            cpu_rst_q <= 1'b0;
                            state_q   <= HI;
                        end
                    end
                end
                HI: if (byte_valid) begin
                    word_q[15:8] <= byte_data;
                    state_q      <= LO;
                end
                LO: if (byte_valid) begin
                    word_q[7:0] <= byte_data;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    csum_q <= csum_q + word_q;
                    cnt_q  <= cnt_d;
                    // CPU release is registered on the edge entering DONE so it coincides with done.
                    if (cnt_d == len_q) begin
                        cpu_rst_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        state_q <= HI;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
